// File: rtl/sensor_request_scheduler.sv
// Request scheduler between the UART command path and the DHT11 sensor block.
// Runs single-shot reads, emulates continuous mode with a period timer, and returns one response pair per request.
module sensor_request_scheduler #(
  parameter int unsigned PERIOD_CYCLES  = 100_000_000,
  parameter int unsigned TIMEOUT_CYCLES = 50_000_000,
  parameter int unsigned NUM_SENSORS    = 1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       req_valid,
  input  logic [7:0] req_command,
  input  logic [7:0] req_address,
  output logic       req_ready,
  output logic       sensor_enable,
  output logic [7:0] sensor_command,
  output logic [7:0] sensor_address,
  input  logic       sensor_done,
  input  logic [7:0] sensor_resp_command,
  input  logic [7:0] sensor_resp_value,
  output logic       tx_valid,
  output logic [7:0] tx_command,
  output logic [7:0] tx_value,
  input  logic       tx_ready
);

  localparam logic [31:0] PERIOD_LAST  = 32'(PERIOD_CYCLES - 1);
  localparam logic [31:0] TIMEOUT_LAST = 32'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT_SENSOR, S_RESPOND, S_CONT_WAIT} state_t;

  state_t      state_q, state_d;
  logic        cont_q, cont_d;
  logic        ready_q, ready_d;
  logic        en_q, en_d;
  logic [7:0]  cmd_q, cmd_d;
  logic [7:0]  addr_q, addr_d;
  logic        tx_valid_q, tx_valid_d;
  logic [7:0]  tx_cmd_q, tx_cmd_d;
  logic [7:0]  tx_val_q, tx_val_d;
  logic [31:0] tcnt_q, tcnt_d;
  logic [31:0] pcnt_q, pcnt_d;
  logic        accept;
  logic        addr_bad;

  assign accept   = req_valid & ready_q;
  assign addr_bad = ({24'd0, req_address} >= NUM_SENSORS);

  always_comb begin
    state_d    = state_q;
    cont_d     = cont_q;
    en_d       = en_q;
    cmd_d      = cmd_q;
    addr_d     = addr_q;
    tx_valid_d = tx_valid_q;
    tx_cmd_d   = tx_cmd_q;
    tx_val_d   = tx_val_q;
    tcnt_d     = tcnt_q;
    // Period counter saturates at expiry, so an expiry masked by a request stays pending.
    pcnt_d     = (pcnt_q != PERIOD_LAST) ? pcnt_q + 32'd1 : pcnt_q;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d    = S_RESPOND;
          tx_valid_d = 1'b1;
          tx_cmd_d   = 8'h45;
          tx_val_d   = 8'h45;
          if (!addr_bad) begin
            case (req_command)
              8'h00, 8'h01, 8'h02: begin
                tx_valid_d = 1'b0;
                cmd_d      = req_command;
                addr_d     = req_address;
                state_d    = S_ISSUE;
              end
              8'h03, 8'h04: begin
                tx_valid_d = 1'b0;
                cont_d     = 1'b1;
                cmd_d      = req_command - 8'd2;
                addr_d     = req_address;
                state_d    = S_ISSUE;
              end
              8'h05, 8'h06: begin
                tx_cmd_d = 8'hAA;
                tx_val_d = 8'hAA;
              end
              default: ;
            endcase
          end
        end
      end
      S_ISSUE: begin
        en_d    = 1'b1;
        tcnt_d  = 32'd0;
        pcnt_d  = 32'd1;
        state_d = S_WAIT_SENSOR;
      end
      S_WAIT_SENSOR: begin
        tcnt_d = tcnt_q + 32'd1;
        if (sensor_done) begin
          en_d       = 1'b0;
          tx_valid_d = 1'b1;
          tx_cmd_d   = sensor_resp_command;
          tx_val_d   = sensor_resp_value;
          state_d    = S_RESPOND;
        end else if (tcnt_q == TIMEOUT_LAST) begin
          en_d       = 1'b0;
          tx_valid_d = 1'b1;
          tx_cmd_d   = 8'h1F;
          tx_val_d   = 8'h1F;
          state_d    = S_RESPOND;
        end
      end
      S_RESPOND: begin
        if (tx_ready) begin
          tx_valid_d = 1'b0;
          state_d    = cont_q ? S_CONT_WAIT : S_IDLE;
        end
      end
      S_CONT_WAIT: begin
        if (accept) begin
          tx_valid_d = 1'b1;
          state_d    = S_RESPOND;
          if (req_command == 8'h05 || req_command == 8'h06) begin
            cont_d   = 1'b0;
            tx_cmd_d = 8'h0A;
            tx_val_d = 8'h0A;
          end else begin
            tx_cmd_d = 8'hFF;
            tx_val_d = 8'hFF;
          end
        end else if (pcnt_q == PERIOD_LAST) begin
          state_d = S_ISSUE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    ready_d = (state_d == S_IDLE) || (state_d == S_CONT_WAIT);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      cont_q     <= 1'b0;
      ready_q    <= 1'b0;
      en_q       <= 1'b0;
      cmd_q      <= 8'd0;
      addr_q     <= 8'd0;
      tx_valid_q <= 1'b0;
      tx_cmd_q   <= 8'd0;
      tx_val_q   <= 8'd0;
      tcnt_q     <= 32'd0;
      pcnt_q     <= 32'd0;
    end else begin
      state_q    <= state_d;
      cont_q     <= cont_d;
      ready_q    <= ready_d;
      en_q       <= en_d;
      cmd_q      <= cmd_d;
      addr_q     <= addr_d;
      tx_valid_q <= tx_valid_d;
      tx_cmd_q   <= tx_cmd_d;
      tx_val_q   <= tx_val_d;
      tcnt_q     <= tcnt_d;
      pcnt_q     <= pcnt_d;
    end
  end

  assign req_ready      = ready_q;
  assign sensor_enable  = en_q;
  assign sensor_command = cmd_q;
  assign sensor_address = addr_q;
  assign tx_valid       = tx_valid_q;
  assign tx_command     = tx_cmd_q;
  assign tx_value       = tx_val_q;

endmodule

// File: tb/tb_sensor_request_scheduler.sv
// Directed bench for sensor_request_scheduler with short period/timeout values.
module tb_sensor_request_scheduler;

  localparam int PERIOD  = 500;
  localparam int TIMEOUT = 1000;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       req_valid = 1'b0;
  logic [7:0] req_command = 8'd0;
  logic [7:0] req_address = 8'd0;
  logic       req_ready;
  logic       sensor_enable;
  logic [7:0] sensor_command;
  logic [7:0] sensor_address;
  logic       sensor_done = 1'b0;
  logic [7:0] sensor_resp_command = 8'd0;
  logic [7:0] sensor_resp_value = 8'd0;
  logic       tx_valid;
  logic [7:0] tx_command;
  logic [7:0] tx_value;
  logic       tx_ready = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  sensor_request_scheduler #(
    .PERIOD_CYCLES (PERIOD),
    .TIMEOUT_CYCLES(TIMEOUT),
    .NUM_SENSORS   (1)
  ) dut (
    .clock              (clock),
    .reset              (reset),
    .req_valid          (req_valid),
    .req_command        (req_command),
    .req_address        (req_address),
    .req_ready          (req_ready),
    .sensor_enable      (sensor_enable),
    .sensor_command     (sensor_command),
    .sensor_address     (sensor_address),
    .sensor_done        (sensor_done),
    .sensor_resp_command(sensor_resp_command),
    .sensor_resp_value  (sensor_resp_value),
    .tx_valid           (tx_valid),
    .tx_command         (tx_command),
    .tx_value           (tx_value),
    .tx_ready           (tx_ready)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
    cyc++;
  endtask

  task automatic send_req(input logic [7:0] c, input logic [7:0] a);
    chk("req_ready_before_send", req_ready, 1);
    req_valid   = 1'b1;
    req_command = c;
    req_address = a;
    tick();
    req_valid = 1'b0;
  endtask

  task automatic sensor_reply(input logic [7:0] c, input logic [7:0] v);
    sensor_done         = 1'b1;
    sensor_resp_command = c;
    sensor_resp_value   = v;
    tick();
    sensor_done = 1'b0;
  endtask

  task automatic ack();
    tx_ready = 1'b1;
    tick();
    tx_ready = 1'b0;
  endtask

  task automatic chk_tx(input string tag, input logic [7:0] c, input logic [7:0] v);
    chk({tag, "_valid"}, tx_valid, 1);
    chk({tag, "_cmd"}, tx_command, c);
    chk({tag, "_val"}, tx_value, v);
  endtask

  task automatic wait_rise(input int limit, output bit found, output int at);
    logic prev;
    prev  = sensor_enable;
    found = 1'b0;
    at    = 0;
    for (int i = 0; i < limit; i++) begin
      tick();
      if (sensor_enable && !prev) begin
        found = 1'b1;
        at    = cyc;
        break;
      end
      prev = sensor_enable;
    end
  endtask

  initial begin
    bit found;
    int r1, r2, r3, r4, n, t_ack;

    // Reset state
    tick();
    tick();
    chk("rst_ready", req_ready, 0);
    chk("rst_en", sensor_enable, 0);
    chk("rst_tx_valid", tx_valid, 0);
    chk("rst_scmd", sensor_command, 0);
    chk("rst_tx_cmd", tx_command, 0);
    reset = 1'b0;
    tick();
    chk("post_rst_ready", req_ready, 1);

    // Single read 0x01 at address 0
    send_req(8'h01, 8'h00);
    chk("rd1_en_lat1", sensor_enable, 0);
    tick();
    chk("rd1_en_lat2", sensor_enable, 1);
    chk("rd1_scmd", sensor_command, 8'h01);
    chk("rd1_saddr", sensor_address, 8'h00);
    repeat (98) tick();
    chk("rd1_en_hold", sensor_enable, 1);
    sensor_reply(8'h09, 8'h19);
    chk_tx("rd1_tx", 8'h09, 8'h19);
    chk("rd1_en_fell", sensor_enable, 0);
    ack();
    chk("rd1_tx_drop", tx_valid, 0);
    chk("rd1_idle_ready", req_ready, 1);

    // Bad address, bad command, stop in IDLE
    send_req(8'h01, 8'h05);
    chk_tx("badaddr_tx", 8'h45, 8'h45);
    chk("badaddr_en", sensor_enable, 0);
    tick();
    chk("badaddr_en2", sensor_enable, 0);
    ack();
    send_req(8'h07, 8'h00);
    chk_tx("badcmd_tx", 8'h45, 8'h45);
    ack();
    send_req(8'h05, 8'h00);
    chk_tx("idle_stop_tx", 8'hAA, 8'hAA);
    ack();

    // Timeout on 0x02
    send_req(8'h02, 8'h00);
    tick();
    chk("to_en", sensor_enable, 1);
    chk("to_scmd", sensor_command, 8'h02);
    n = 1;
    for (int i = 0; i < 1100; i++) begin
      tick();
      if (sensor_enable) n++;
      else break;
    end
    chk("to_en_len", n, TIMEOUT);
    chk_tx("to_tx", 8'h1F, 8'h1F);
    ack();

    // sensor_done on the last timeout cycle beats the timeout
    send_req(8'h01, 8'h00);
    tick();
    repeat (TIMEOUT - 1) tick();
    chk("dw_en", sensor_enable, 1);
    sensor_reply(8'h01, 8'h33);
    chk_tx("dw_tx", 8'h01, 8'h33);
    chk("dw_en_fell", sensor_enable, 0);
    ack();

    // Continuous mode via 0x03
    send_req(8'h03, 8'h00);
    wait_rise(5, found, r1);
    chk("c1_rise", found, 1);
    chk("c1_scmd", sensor_command, 8'h01);
    repeat (4) tick();
    sensor_reply(8'h01, 8'h2A);
    chk_tx("c1_tx", 8'h01, 8'h2A);
    ack();
    chk("c1_cont_ready", req_ready, 1);
    wait_rise(600, found, r2);
    chk("c2_rise", found, 1);
    chk("c2_period", r2 - r1, PERIOD);
    chk("c2_scmd", sensor_command, 8'h01);
    repeat (4) tick();
    sensor_reply(8'h01, 8'h2B);
    ack();
    send_req(8'h02, 8'h00);
    chk_tx("c2_busy_tx", 8'hFF, 8'hFF);
    repeat (20) tick();
    chk_tx("c2_hold_tx", 8'hFF, 8'hFF);
    ack();
    wait_rise(600, found, r3);
    chk("c3_rise", found, 1);
    chk("c3_period", r3 - r2, PERIOD);
    chk("c3_scmd", sensor_command, 8'h01);
    repeat (4) tick();
    sensor_reply(8'h01, 8'h2C);
    ack();
    // Request lands in the same cycle as period expiry
    while (cyc < r3 + PERIOD - 2) tick();
    send_req(8'h02, 8'h00);
    chk_tx("col_tx", 8'hFF, 8'hFF);
    chk("col_en", sensor_enable, 0);
    repeat (3) tick();
    ack();
    t_ack = cyc;
    wait_rise(10, found, r4);
    chk("col_pending_rise", found, 1);
    chk("col_rise_lat", r4 - t_ack, 2);
    chk("col_scmd", sensor_command, 8'h01);
    sensor_reply(8'h01, 8'h2D);
    ack();
    send_req(8'h05, 8'h00);
    chk_tx("stop_tx", 8'h0A, 8'h0A);
    ack();
    chk("stop_idle_ready", req_ready, 1);
    wait_rise(600, found, r1);
    chk("stop_no_rise", found, 0);

    // Reset during WAIT_SENSOR in continuous mode
    send_req(8'h04, 8'h00);
    wait_rise(5, found, r1);
    chk("rr_rise", found, 1);
    chk("rr_scmd", sensor_command, 8'h02);
    repeat (5) tick();
    reset = 1'b1;
    #1;
    chk("rr_en_async", sensor_enable, 0);
    chk("rr_tx_async", tx_valid, 0);
    chk("rr_ready_async", req_ready, 0);
    chk("rr_scmd_async", sensor_command, 0);
    tick();
    reset = 1'b0;
    tick();
    chk("rr_ready_after", req_ready, 1);
    wait_rise(600, found, r1);
    chk("rr_cont_cleared", found, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
